// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (A) vs buffered long-latency results (B).
// A has priority; a starvation counter forces the B FIFO head through when it has waited too long.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [REG_ADDR_W-1:0]         a_rd,
    input  logic [XLEN-1:0]               a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [REG_ADDR_W-1:0]         b_rd,
    input  logic [XLEN-1:0]               b_data,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   b_count,
    output logic                          starve_force
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  STARVE_TOP = SC_W'(STARVE_MAX - 1);

    logic [REG_ADDR_W-1:0] rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0]       data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [SC_W-1:0]       starve_cnt;

    logic head_v;
    logic force_b;
    logic grant_a;
    logic grant_b;
    logic push;
    logic pop;

    always_comb begin
        head_v       = (b_count != '0);
        force_b      = head_v && (starve_cnt >= STARVE_TOP);
        starve_force = force_b;
        a_ready      = !force_b;
        b_ready      = (b_count != FULL_CNT);
        grant_a      = a_valid && a_ready;
        grant_b      = head_v && (force_b || !a_valid);
        push         = b_valid && b_ready;
        pop          = grant_b;
    end

    // Storage carries no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr]   <= b_rd;
            data_mem[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            b_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      b_count <= b_count + 1'b1;
            else if (pop && !push) b_count <= b_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_b || !head_v) begin
            starve_cnt <= '0;
        end else if (starve_cnt < STARVE_TOP) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Writes to x0 complete the handshake but never assert the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant_a) begin
            rf_we    <= (a_rd != '0);
            rf_waddr <= a_rd;
            rf_wdata <= a_data;
        end else if (grant_b) begin
            rf_we    <= (rd_mem[rd_ptr] != '0);
            rf_waddr <= rd_mem[rd_ptr];
            rf_wdata <= data_mem[rd_ptr];
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default parameters: depth 2, STARVE_MAX 4).
module tb_wb_port_arbiter;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic                        clk;
    logic                        rst_n;
    logic                        a_valid;
    logic                        a_ready;
    logic [REG_ADDR_W-1:0]       a_rd;
    logic [XLEN-1:0]             a_data;
    logic                        b_valid;
    logic                        b_ready;
    logic [REG_ADDR_W-1:0]       b_rd;
    logic [XLEN-1:0]             b_data;
    logic                        rf_we;
    logic [REG_ADDR_W-1:0]       rf_waddr;
    logic [XLEN-1:0]             rf_wdata;
    logic [$clog2(FIFO_DEPTH):0] b_count;
    logic                        starve_force;

    int n_cmp;
    int n_bad;

    wb_port_arbiter #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .b_count      (b_count),
        .starve_force (starve_force)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants sampled on the falling edge, away from input changes.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("one_grant", 64'(dut.grant_a && dut.grant_b), 64'd0);
            check_eq("count_bound", 64'(b_count <= FIFO_DEPTH), 64'd1);
            check_eq("no_full_push", 64'(b_ready && (b_count == FIFO_DEPTH)), 64'd0);
        end
    end

    initial begin
        #100000;
        n_bad++;
        $display("FAIL timeout: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        logic [REG_ADDR_W-1:0] s3_ard   [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd5};
        logic                  s3_force [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [REG_ADDR_W-1:0] s3_waddr [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9, 5'd5};
        logic                  s4_bready[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic                  s4_force [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int unsigned           s4_count [9] = '{0, 1, 2, 2, 2, 1, 2, 2, 2};
        logic [REG_ADDR_W-1:0] s4_waddr [9] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd24, 5'd25, 5'd26, 5'd11};
        int unsigned acc;
        int unsigned pushes;

        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_rd    = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_rd    = '0;
        b_data  = '0;

        #2;
        check_eq("rst_we", 64'(rf_we), 64'd0);
        check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
        check_eq("rst_wdata", 64'(rf_wdata), 64'd0);
        check_eq("rst_count", 64'(b_count), 64'd0);
        check_eq("rst_bready", 64'(b_ready), 64'd1);
        check_eq("rst_aready", 64'(a_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single A write, then idle.
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
        #1 check_eq("a1_ready", 64'(a_ready), 64'd1);
        tick();
        check_eq("a1_we", 64'(rf_we), 64'd1);
        check_eq("a1_waddr", 64'(rf_waddr), 64'd5);
        check_eq("a1_wdata", 64'(rf_wdata), 64'h11);
        a_valid = 1'b0;
        tick();
        check_eq("a1_idle_we", 64'(rf_we), 64'd0);
        check_eq("a1_hold_waddr", 64'(rf_waddr), 64'd5);

        // Single B write with A idle.
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hABCD;
        #1 check_eq("b1_ready", 64'(b_ready), 64'd1);
        tick();
        b_valid = 1'b0;
        #1 check_eq("b1_count1", 64'(b_count), 64'd1);
        check_eq("b1_noforce", 64'(starve_force), 64'd0);
        tick();
        check_eq("b1_we", 64'(rf_we), 64'd1);
        check_eq("b1_waddr", 64'(rf_waddr), 64'd7);
        check_eq("b1_wdata", 64'(rf_wdata), 64'hABCD);
        check_eq("b1_count0", 64'(b_count), 64'd0);
        tick();
        check_eq("b1_idle_we", 64'(rf_we), 64'd0);

        // A saturating, one B entry: loses three cycles then is forced.
        for (int c = 0; c < 6; c++) begin
            a_valid = 1'b1;
            a_rd    = s3_ard[c];
            a_data  = 32'hA000 + 32'(s3_ard[c]);
            b_valid = (c == 0);
            b_rd    = 5'd9;
            b_data  = 32'hB009;
            #1;
            check_eq($sformatf("s3_force%0d", c), 64'(starve_force), 64'(s3_force[c]));
            check_eq($sformatf("s3_aready%0d", c), 64'(a_ready), 64'(!s3_force[c]));
            tick();
            check_eq($sformatf("s3_waddr%0d", c), 64'(rf_waddr), 64'(s3_waddr[c]));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        tick();

        // A saturating, B streaming: FIFO fills, forced pops keep B order.
        acc = 0;
        pushes = 0;
        for (int c = 0; c < 9; c++) begin
            a_valid = 1'b1;
            a_rd    = REG_ADDR_W'(20 + acc);
            a_data  = 32'hA000 + 32'(20 + acc);
            b_valid = 1'b1;
            b_rd    = REG_ADDR_W'(10 + pushes);
            b_data  = 32'hB000 + 32'(10 + pushes);
            #1;
            check_eq($sformatf("s4_bready%0d", c), 64'(b_ready), 64'(s4_bready[c]));
            check_eq($sformatf("s4_force%0d", c), 64'(starve_force), 64'(s4_force[c]));
            check_eq($sformatf("s4_count%0d", c), 64'(b_count), 64'(s4_count[c]));
            if (!s4_force[c]) acc++;
            if (s4_bready[c]) pushes++;
            tick();
            check_eq($sformatf("s4_waddr%0d", c), 64'(rf_waddr), 64'(s4_waddr[c]));
            check_eq($sformatf("s4_wdata%0d", c), 64'(rf_wdata),
                     64'(s4_force[c] ? 32'hB000 + 32'(s4_waddr[c]) : 32'hA000 + 32'(s4_waddr[c])));
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1 check_eq("s4_drain_count", 64'(b_count), 64'd1);
        tick();
        check_eq("s4_drain_waddr", 64'(rf_waddr), 64'd12);
        check_eq("s4_drain_wdata", 64'(rf_wdata), 64'hB00C);
        check_eq("s4_empty", 64'(b_count), 64'd0);

        // Writes to x0 are consumed without a write enable.
        a_valid = 1'b1; a_rd = '0; a_data = 32'hFFFF;
        #1 check_eq("x0a_ready", 64'(a_ready), 64'd1);
        tick();
        check_eq("x0a_we", 64'(rf_we), 64'd0);
        check_eq("x0a_wdata", 64'(rf_wdata), 64'hFFFF);
        a_valid = 1'b0;
        b_valid = 1'b1; b_rd = '0; b_data = 32'h1234;
        tick();
        b_valid = 1'b0;
        #1 check_eq("x0b_count1", 64'(b_count), 64'd1);
        tick();
        check_eq("x0b_we", 64'(rf_we), 64'd0);
        check_eq("x0b_count0", 64'(b_count), 64'd0);
        check_eq("x0b_wdata", 64'(rf_wdata), 64'h1234);

        // Asynchronous reset mid-cycle with two buffered B entries.
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h3;
        b_valid = 1'b1; b_rd = 5'd13; b_data = 32'hB00D;
        tick();
        b_rd = 5'd14; b_data = 32'hB00E;
        tick();
        b_valid = 1'b0;
        #1 check_eq("ar_count2", 64'(b_count), 64'd2);
        check_eq("ar_we_before", 64'(rf_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_we", 64'(rf_we), 64'd0);
        check_eq("ar_count", 64'(b_count), 64'd0);
        check_eq("ar_bready", 64'(b_ready), 64'd1);
        a_valid = 1'b0;
        #1 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq($sformatf("ar_post_we%0d", c), 64'(rf_we), 64'd0);
            check_eq($sformatf("ar_post_count%0d", c), 64'(b_count), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
